sub_32bit_serial: RTL

SUB_32BIT_SERIAL -- requirements
Module: sub_32bit_serial

---
 rtl/sub_32bit_serial.sv | 114 +++++++++++
 1 files changed

// File: rtl/sub_32bit_serial.sv
// Nibble-serial subtractor: computes a - b - b_in over NIBBLES clock cycles,
// one 4-bit slice per cycle, with a registered result, borrow-out and signed overflow.
module sub_32bit_serial #(
  parameter int NIBBLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   b_in,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   b_out,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-5:0]    res_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic            a_sign_r;
  logic            b_sign_r;
  logic [4:0]      sum_s;
  logic            last_slice_s;

  // Current slice: a + ~b + carry; carry-out is the inverted borrow.
  always_comb begin
    sum_s        = {1'b0, a_r[3:0]} + {1'b0, ~b_r[3:0]} + {4'b0000, carry_r};
    last_slice_s = (idx_r == IW'(NIBBLES - 1));
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_slice_s) state_nxt_s = DONE;
        else              state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, slice datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      res_r    <= {(W-4){1'b0}};
      idx_r    <= {IW{1'b0}};
      carry_r  <= 1'b0;
      a_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      diff     <= {W{1'b0}};
      b_out    <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s == RUN);
      done    <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            a_sign_r <= a[W-1];
            b_sign_r <= b[W-1];
            carry_r  <= ~b_in;
            idx_r    <= {IW{1'b0}};
          end
        end
        RUN: begin
          // Operands shift down so the active slice is always bits [3:0];
          // results enter from the top so the final slice lands in place.
          a_r     <= {4'b0000, a_r[W-1:4]};
          b_r     <= {4'b0000, b_r[W-1:4]};
          res_r   <= {sum_s[3:0], res_r[W-5:4]};
          carry_r <= sum_s[4];
          idx_r   <= idx_r + IW'(1);
          if (last_slice_s) begin
            diff     <= {sum_s[3:0], res_r};
            b_out    <= ~sum_s[4];
            overflow <= (a_sign_r != b_sign_r) && (sum_s[3] != a_sign_r);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
